// File: rtl/cmp_pkg.sv
// Shared definitions for the framed min/max tracker: default widths,
// result-FSM encoding and the saturation limit for the default counter width.
package cmp_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    // 2'd3 is unused and recovers to FIRST
    typedef enum logic [1:0] {
        FIRST = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned CNT_MAX = (2 ** CNT_W_DEF) - 1;

endpackage

// File: rtl/mag_cmp.sv
// Unsigned WIDTH-bit magnitude comparator; exactly one of lt/eq/gt is high.
module mag_cmp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o
);

    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);
    assign gt_o = ~(lt_o | eq_o);

endmodule

// File: rtl/stream_min_max.sv
// Tracks running min/max (first-occurrence indices) and sample count per frame,
// presenting the result over a valid/ready handshake once the last beat lands.
module stream_min_max
    import cmp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [CNT_W-1:0] CNT_LIM = '1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   min_q, min_d;
    logic [WIDTH-1:0]   max_q, max_d;
    logic [CNT_W-1:0]   min_idx_q, min_idx_d;
    logic [CNT_W-1:0]   max_idx_q, max_idx_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sat_q, sat_d;

    logic lt_min, eq_min, gt_min;
    logic lt_max, eq_max, gt_max;
    logic cmp_unused;
    logic beat;

    mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
        .a_i  (in_data),
        .b_i  (min_q),
        .lt_o (lt_min),
        .eq_o (eq_min),
        .gt_o (gt_min)
    );

    mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
        .a_i  (in_data),
        .b_i  (max_q),
        .lt_o (lt_max),
        .eq_o (eq_max),
        .gt_o (gt_max)
    );

    // Only strict lt against min and strict gt against max drive updates
    assign cmp_unused = &{1'b0, eq_min, gt_min, lt_max, eq_max};

    assign in_ready  = (state_q == FIRST) || (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign beat      = in_valid && in_ready;

    assign out_min     = min_q;
    assign out_max     = max_q;
    assign out_min_idx = min_idx_q;
    assign out_max_idx = max_idx_q;
    assign out_count   = count_q;
    assign out_sat     = sat_q;

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        count_d   = count_q;
        sat_d     = sat_q;
        case (state_q)
            FIRST: begin
                if (beat) begin
                    min_d     = in_data;
                    max_d     = in_data;
                    min_idx_d = '0;
                    max_idx_d = '0;
                    count_d   = CNT_W'(1);
                    sat_d     = 1'b0;
                    state_d   = in_last ? DONE : RUN;
                end
            end
            RUN: begin
                if (beat) begin
                    // count_q never exceeds CNT_LIM, so it doubles as the clamped position
                    if (lt_min) begin
                        min_d     = in_data;
                        min_idx_d = count_q;
                    end
                    if (gt_max) begin
                        max_d     = in_data;
                        max_idx_d = count_q;
                    end
                    if (count_q == CNT_LIM) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = FIRST;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FIRST;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
        end
    end

endmodule

// File: tb/tb_stream_min_max.sv
// Randomised and directed frames driven into two instances (CNT_W=16 and CNT_W=4)
// and checked every cycle against a frame-level reference model.
module tb_stream_min_max;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid, in_last, out_ready;

    logic        in_ready_a, out_valid_a, out_sat_a;
    logic [31:0] out_min_a, out_max_a;
    logic [15:0] out_min_idx_a, out_max_idx_a, out_count_a;

    logic        in_ready_b, out_valid_b, out_sat_b;
    logic [31:0] out_min_b, out_max_b;
    logic [3:0]  out_min_idx_b, out_max_idx_b, out_count_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] mn;
        logic [31:0] mx;
        int          mn_i;
        int          mx_i;
        int          cnt;
        bit          sat;
    } res_t;

    logic [31:0] frame_q[$];
    bit          pending = 1'b0;
    res_t        ra, rb;

    always #5 clk = ~clk;

    stream_min_max #(.WIDTH(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_a), .out_min(out_min_a), .out_max(out_max_a),
        .out_min_idx(out_min_idx_a), .out_max_idx(out_max_idx_a), .out_count(out_count_a),
        .out_sat(out_sat_a), .out_valid(out_valid_a), .out_ready(out_ready)
    );

    stream_min_max #(.WIDTH(32), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_b), .out_min(out_min_b), .out_max(out_max_b),
        .out_min_idx(out_min_idx_b), .out_max_idx(out_max_idx_b), .out_count(out_count_b),
        .out_sat(out_sat_b), .out_valid(out_valid_b), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame result straight from the definition: first occurrence of min/max,
    // with count and positions clamped at 2^cw-1.
    function automatic res_t calc(input int cw);
        res_t r;
        int   lim = (1 << cw) - 1;
        int   n   = frame_q.size();
        r.mn = frame_q[0]; r.mn_i = 0;
        r.mx = frame_q[0]; r.mx_i = 0;
        for (int i = 1; i < n; i++) begin
            if (frame_q[i] < r.mn) begin r.mn = frame_q[i]; r.mn_i = i; end
            if (frame_q[i] > r.mx) begin r.mx = frame_q[i]; r.mx_i = i; end
        end
        r.cnt  = (n > lim) ? lim : n;
        r.sat  = (n > lim);
        r.mn_i = (r.mn_i > lim) ? lim : r.mn_i;
        r.mx_i = (r.mx_i > lim) ? lim : r.mx_i;
        return r;
    endfunction

    task automatic check_model();
        chk("in_ready_a", 64'(in_ready_a), 64'(!pending));
        chk("out_valid_a", 64'(out_valid_a), 64'(pending));
        chk("in_ready_b", 64'(in_ready_b), 64'(!pending));
        chk("out_valid_b", 64'(out_valid_b), 64'(pending));
        if (pending) begin
            chk("min_a", 64'(out_min_a), 64'(ra.mn));
            chk("max_a", 64'(out_max_a), 64'(ra.mx));
            chk("min_idx_a", 64'(out_min_idx_a), 64'(ra.mn_i));
            chk("max_idx_a", 64'(out_max_idx_a), 64'(ra.mx_i));
            chk("count_a", 64'(out_count_a), 64'(ra.cnt));
            chk("sat_a", 64'(out_sat_a), 64'(ra.sat));
            chk("min_b", 64'(out_min_b), 64'(rb.mn));
            chk("max_b", 64'(out_max_b), 64'(rb.mx));
            chk("min_idx_b", 64'(out_min_idx_b), 64'(rb.mn_i));
            chk("max_idx_b", 64'(out_max_idx_b), 64'(rb.mx_i));
            chk("count_b", 64'(out_count_b), 64'(rb.cnt));
            chk("sat_b", 64'(out_sat_b), 64'(rb.sat));
        end
    endtask

    // Predict the state after the coming edge from the inputs held now
    task automatic update_model();
        if (rst) begin
            frame_q.delete();
            pending = 1'b0;
        end else if (pending) begin
            if (out_ready) pending = 1'b0;
        end else if (in_valid) begin
            frame_q.push_back(in_data);
            if (in_last) begin
                ra = calc(16);
                rb = calc(4);
                pending = 1'b1;
                frame_q.delete();
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic gap(input logic last);
        in_valid = 1'b0;
        in_last  = last;
        in_data  = $urandom;
        tick();
        in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !out_valid_a; i++) tick();
        chk("result_timeout", 64'(out_valid_a), 64'd1);
    endtask

    task automatic release_result(input int hold);
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd_data();
        logic [31:0] d;
        case ($urandom_range(0, 3))
            0:       d = 32'h0;
            1:       d = 32'hFFFF_FFFF;
            2:       d = 32'($urandom_range(0, 7));
            default: d = $urandom;
        endcase
        return d;
    endfunction

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_out_min", 64'(out_min_a), 64'd0);
        chk("rst_out_count", 64'(out_count_a), 64'd0);
        chk("rst_out_sat", 64'(out_sat_a), 64'd0);

        // 5,3,9,3,9
        beat(32'd5, 1'b0); beat(32'd3, 1'b0); beat(32'd9, 1'b0); beat(32'd3, 1'b0);
        beat(32'd9, 1'b1);
        chk("lat_valid", 64'(out_valid_a), 64'd1);
        wait_valid();
        chk("f1_min", 64'(out_min_a), 64'd3);
        chk("f1_min_idx", 64'(out_min_idx_a), 64'd1);
        chk("f1_max", 64'(out_max_a), 64'd9);
        chk("f1_max_idx", 64'(out_max_idx_a), 64'd2);
        chk("f1_count", 64'(out_count_a), 64'd5);
        chk("f1_sat", 64'(out_sat_a), 64'd0);
        release_result(0);

        // single all-ones beat
        beat(32'hFFFF_FFFF, 1'b1);
        wait_valid();
        chk("f2_min", 64'(out_min_a), 64'hFFFF_FFFF);
        chk("f2_max", 64'(out_max_a), 64'hFFFF_FFFF);
        chk("f2_idx", 64'({out_min_idx_a, out_max_idx_a}), 64'd0);
        chk("f2_count", 64'(out_count_a), 64'd1);
        release_result(1);

        // backpressure hold on 7,1
        beat(32'd7, 1'b0); beat(32'd1, 1'b1);
        wait_valid();
        repeat (10) tick();
        chk("f3_min", 64'(out_min_a), 64'd1);
        chk("f3_min_idx", 64'(out_min_idx_a), 64'd1);
        chk("f3_max", 64'(out_max_a), 64'd7);
        chk("f3_max_idx", 64'(out_max_idx_a), 64'd0);
        chk("f3_in_ready", 64'(in_ready_a), 64'd0);
        release_result(0);
        chk("f3_after_valid", 64'(out_valid_a), 64'd0);
        chk("f3_after_ready", 64'(in_ready_a), 64'd1);

        // idle beats with in_last=1 must be ignored
        beat(32'd4, 1'b0); gap(1'b1); beat(32'd2, 1'b0); gap(1'b1); beat(32'd8, 1'b1);
        wait_valid();
        chk("f4_min", 64'(out_min_a), 64'd2);
        chk("f4_min_idx", 64'(out_min_idx_a), 64'd1);
        chk("f4_max", 64'(out_max_a), 64'd8);
        chk("f4_max_idx", 64'(out_max_idx_a), 64'd2);
        chk("f4_count", 64'(out_count_a), 64'd3);
        release_result(2);

        // reset mid-frame
        beat(32'd11, 1'b0); beat(32'd12, 1'b0); beat(32'd13, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_in_ready", 64'(in_ready_a), 64'd1);
        chk("mrst_out_valid", 64'(out_valid_a), 64'd0);
        beat(32'd6, 1'b1);
        wait_valid();
        chk("f5_count", 64'(out_count_a), 64'd1);
        chk("f5_min", 64'(out_min_a), 64'd6);
        chk("f5_max", 64'(out_max_a), 64'd6);
        release_result(0);

        // 1..20 saturates the CNT_W=4 instance
        for (int i = 1; i <= 20; i++) beat(32'(i), (i == 20));
        wait_valid();
        chk("f6_count_b", 64'(out_count_b), 64'd15);
        chk("f6_sat_b", 64'(out_sat_b), 64'd1);
        chk("f6_max_idx_b", 64'(out_max_idx_b), 64'd15);
        chk("f6_max_b", 64'(out_max_b), 64'd20);
        chk("f6_min_b", 64'(out_min_b), 64'd1);
        chk("f6_min_idx_b", 64'(out_min_idx_b), 64'd0);
        chk("f6_count_a", 64'(out_count_a), 64'd20);
        chk("f6_sat_a", 64'(out_sat_a), 64'd0);
        release_result(1);
        chk("f6_sat_cleared", 64'(out_sat_b), 64'd0);

        // random frames
        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(1, 24);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) gap($urandom_range(0, 1) == 1);
                beat(rnd_data(), (k == len - 1));
            end
            wait_valid();
            release_result($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
